dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the processor's load/store path and an external requester (program loader or display engine).
- Memory has fixed read latency, so CPU accesses can no longer finish in one cycle. The arbiter therefore also generates the CPU stall that freezes the PC and register writeback until the access completes.
- Sits between the datapath's memory port (driven by MemWrite/MemtoReg) and the memory macro.
- One transaction is outstanding at a time.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port, fixed-latency data memory between the
//               CPU load/store path and an external requester. It issues one
//               transaction at a time, stalls the CPU until its access
//               completes, and bounds external starvation with a loss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,   // legal 1..7
    parameter int STARVE_MAX = 4    // legal 1..15
) (
    input  logic              clk,
    input  logic              reset,          // asynchronous, active-low

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              ext_req_valid,
    output logic              ext_req_ready,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_rsp_valid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_CPU = 2'd1,
        ST_BUSY_EXT = 2'd2
    } state_t;

    localparam logic [2:0] C_MEM_LAT    = 3'(MEM_LAT);
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [3:0] C_STARVE_SAT = 4'hF;

    state_t      state_q,      state_d;
    logic [2:0]  lat_cnt_q,    lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    // Direction of the in-flight access; selects rdata versus zero on completion.
    logic        busy_we_q,    busy_we_d;

    logic w_both_req;
    logic w_ext_wins;
    logic w_cpu_wins;
    logic w_done;

    // Arbitration: a lone requester wins; on conflict the CPU wins until the
    // external side has lost STARVE_MAX times in a row.
    assign w_both_req = cpu_req & ext_req_valid;
    assign w_ext_wins = ext_req_valid & (~cpu_req | (starve_cnt_q >= C_STARVE_MAX));
    assign w_cpu_wins = cpu_req & ~w_ext_wins;
    assign w_done     = (state_q != ST_IDLE) && (lat_cnt_q == C_MEM_LAT);

    // State and support registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= 3'd0;
            starve_cnt_q <= 4'd0;
            busy_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            busy_we_q    <= busy_we_d;
        end
    end

    // Next-state logic and all outputs; outputs are forced idle while in reset.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        starve_cnt_d  = starve_cnt_q;
        busy_we_d     = busy_we_q;

        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        ext_req_ready = 1'b0;
        ext_rsp_valid = 1'b0;
        ext_rdata     = '0;
        cpu_rdata     = '0;
        cpu_stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_ext_wins) begin
                    state_d      = ST_BUSY_EXT;
                    lat_cnt_d    = 3'd1;
                    busy_we_d    = ext_we;
                    starve_cnt_d = 4'd0;
                end else if (w_cpu_wins) begin
                    state_d   = ST_BUSY_CPU;
                    lat_cnt_d = 3'd1;
                    busy_we_d = cpu_we;
                    if (w_both_req && (starve_cnt_q != C_STARVE_SAT)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            ST_BUSY_CPU, ST_BUSY_EXT: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                if (w_done) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = 3'd0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = 3'd0;
            end
        endcase

        if (reset) begin
            // The memory port is driven only in the IDLE issue cycle.
            if (state_q == ST_IDLE) begin
                if (w_ext_wins) begin
                    mem_en        = 1'b1;
                    mem_we        = ext_we;
                    mem_addr      = ext_addr;
                    mem_wdata     = ext_wdata;
                    ext_req_ready = 1'b1;
                end else if (w_cpu_wins) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
            end

            // The CPU is released only in its own completion cycle.
            cpu_stall = cpu_req & ~((state_q == ST_BUSY_CPU) && w_done);

            if ((state_q == ST_BUSY_CPU) && w_done && !busy_we_q) begin
                cpu_rdata = mem_rdata;
            end

            if ((state_q == ST_BUSY_EXT) && w_done) begin
                ext_rsp_valid = 1'b1;
                if (!busy_we_q) begin
                    ext_rdata = mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a fixed-latency
//               memory model; table-driven vectors plus corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int OW         = 133;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              ext_req_valid, ext_req_ready, ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata, ext_rdata;
    logic              ext_rsp_valid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rsp_valid(ext_rsp_valid),
        .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: writes commit at issue, read data appears MEM_LAT cycles later.
    logic [31:0] mem     [0:255];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'hBAD0BAD0;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    typedef struct {
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wd;
        logic        e_v, e_we;
        logic [31:0] e_addr, e_wd;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [OW-1:0] packx(input logic en, input logic we,
            input logic [31:0] addr, input logic [31:0] wd, input logic stall,
            input logic [31:0] crd, input logic rdy, input logic rsp, input logic [31:0] erd);
        return {en, we, addr, wd, stall, crd, rdy, rsp, erd};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, cpu_rdata,
                ext_req_ready, ext_rsp_valid, ext_rdata};
    endfunction

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [31:0] caddr,
            input logic [31:0] cwd, input logic ev, input logic ewe, input logic [31:0] eaddr,
            input logic [31:0] ewd, input logic [OW-1:0] exp);
        vec_t v;
        v.c_req = creq; v.c_we = cwe; v.c_addr = caddr; v.c_wd = cwd;
        v.e_v = ev; v.e_we = ewe; v.e_addr = eaddr; v.e_wd = ewd; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
        ext_req_valid = v.e_v; ext_we = v.e_we; ext_addr = v.e_addr; ext_wdata = v.e_wd;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = 32'h0;

        // Test 1: CPU load alone
        vecs[0]  = mk(1,0,32'h40,0, 0,0,0,0, packx(1,0,32'h40,0,1,0,0,0,0));
        vecs[1]  = mk(1,0,32'h40,0, 0,0,0,0, packx(0,0,0,0,1,0,0,0,0));
        vecs[2]  = mk(1,0,32'h40,0, 0,0,0,0, packx(0,0,0,0,0,32'hDEADBEEF,0,0,0));
        vecs[3]  = mk(0,0,0,0,      0,0,0,0, packx(0,0,0,0,0,0,0,0,0));
        // Test 2: ext write then ext read back
        vecs[4]  = mk(0,0,0,0, 1,1,32'h80,32'h12345678, packx(1,1,32'h80,32'h12345678,0,0,1,0,0));
        vecs[5]  = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,0,0));
        vecs[6]  = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,1,0));
        vecs[7]  = mk(0,0,0,0, 1,0,32'h80,0, packx(1,0,32'h80,0,0,0,1,0,0));
        vecs[8]  = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,0,0));
        vecs[9]  = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,1,32'h12345678));
        // Test 3: conflict, CPU wins, ext follows
        vecs[10] = mk(1,0,32'h40,0, 1,0,32'h80,0, packx(1,0,32'h40,0,1,0,0,0,0));
        vecs[11] = mk(1,0,32'h40,0, 1,0,32'h80,0, packx(0,0,0,0,1,0,0,0,0));
        vecs[12] = mk(1,0,32'h40,0, 1,0,32'h80,0, packx(0,0,0,0,0,32'hDEADBEEF,0,0,0));
        vecs[13] = mk(0,0,0,0,      1,0,32'h80,0, packx(1,0,32'h80,0,0,0,1,0,0));
        vecs[14] = mk(0,0,0,0,      0,0,0,0,      packx(0,0,0,0,0,0,0,0,0));
        vecs[15] = mk(0,0,0,0,      0,0,0,0,      packx(0,0,0,0,0,0,0,1,32'h12345678));
        // Test 6: ext write held pending behind a CPU store
        vecs[16] = mk(1,1,32'h20,32'hA5A5A5A5, 1,1,32'h30,32'hCAFEF00D,
                      packx(1,1,32'h20,32'hA5A5A5A5,1,0,0,0,0));
        vecs[17] = mk(1,1,32'h20,32'hA5A5A5A5, 1,1,32'h30,32'hCAFEF00D,
                      packx(0,0,0,0,1,0,0,0,0));
        vecs[18] = mk(1,1,32'h20,32'hA5A5A5A5, 1,1,32'h30,32'hCAFEF00D,
                      packx(0,0,0,0,0,0,0,0,0));
        vecs[19] = mk(0,0,0,0, 1,1,32'h30,32'hCAFEF00D, packx(1,1,32'h30,32'hCAFEF00D,0,0,1,0,0));
        vecs[20] = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,0,0));
        vecs[21] = mk(0,0,0,0, 0,0,0,0, packx(0,0,0,0,0,0,0,1,0));

        // Reset state, with a CPU request present to show the stall is forced low
        reset = 1'b0;
        drive(mk(1,1,32'h10,32'h55, 1,1,32'h80,32'h1, 0));
        #3;
        check("reset_outputs", outs(), '0);
        check("reset_starve", OW'(dut.starve_cnt_q), '0);
        drive(mk(0,0,0,0, 0,0,0,0, 0));
        next_cycle();
        next_cycle();
        reset = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            next_cycle();
        end

        // Test 4: CPU back-to-back loads against a held ext request
        begin
            int  grants;
            bit  got_ext;
            grants  = 0;
            got_ext = 1'b0;
            drive(mk(1,0,32'h40,0, 1,0,32'h80,0, 0));
            for (int cyc = 0; cyc < 40 && !got_ext; cyc++) begin
                #3;
                if (mem_en) begin
                    check($sformatf("starve_grant%0d_is_ext", grants),
                          OW'(ext_req_ready), OW'(grants == 4));
                    grants++;
                    if (ext_req_ready) got_ext = 1'b1;
                end
                next_cycle();
            end
            check("starve_ext_granted", OW'(got_ext), OW'(1));
            ext_req_valid = 1'b0;
            #3;
            check("starve_cnt_cleared", OW'(dut.starve_cnt_q), '0);
            check("starve_ext_busy", outs(), packx(0,0,0,0,1,0,0,0,0));
            next_cycle(); #3;
            check("starve_ext_done", outs(), packx(0,0,0,0,1,0,0,1,32'h12345678));
            next_cycle(); #3;
            check("starve_cpu_reissue", outs(), packx(1,0,32'h40,0,1,0,0,0,0));
            cpu_req = 1'b0;
            for (int i = 0; i < 4; i++) next_cycle();
        end

        // Test 5: reset in the middle of an ext read
        drive(mk(0,0,0,0, 1,0,32'h80,0, 0));
        #3;
        check("rst_ext_issue", outs(), packx(1,0,32'h80,0,0,0,1,0,0));
        next_cycle();
        ext_req_valid = 1'b0;
        #1 reset = 1'b0;
        drive(mk(1,1,32'h10,32'h55, 0,0,0,0, 0));
        #1;
        check("rst_mid_outputs", outs(), '0);
        check("rst_mid_starve", OW'(dut.starve_cnt_q), '0);
        next_cycle(); #1;
        check("rst_no_rsp", outs(), '0);
        next_cycle();
        reset = 1'b1;
        #1;
        check("rst_after_store_issue", outs(), packx(1,1,32'h10,32'h55,1,0,0,0,0));
        next_cycle(); #3;
        check("rst_after_busy", outs(), packx(0,0,0,0,1,0,0,0,0));
        next_cycle(); #3;
        check("rst_after_done", outs(), packx(0,0,0,0,0,0,0,0,0));
        cpu_req = 1'b0;
        next_cycle(); #3;
        check("rst_store_committed", OW'(mem[8'h10]), OW'(32'h55));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
